// File: rtl/serial_tx_port.sv
// serial_tx_port: register-mapped 8N1 serial transmitter with a small transmit FIFO
module serial_tx_port #(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] RESET_DIVISOR = 16'h0001
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       Port_Enable,
  input  logic [2:0] RegSelect,
  input  logic       WE_L,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       TxD,
  output logic       TxBusy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic armed, tx_en, ovr;
  logic [15:0] div, cnt, period;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [7:0] shreg, lsr;
  logic [2:0] bit_idx;
  logic access, wr, rd, empty, full, push, pop, flush, bit_end;
  assign access  = Port_Enable & armed;
  assign wr      = access & ~WE_L;
  assign rd      = access & WE_L;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign period  = div == '0 ? 16'd1 : div;
  assign bit_end = cnt == 16'd1;
  // a new frame starts from IDLE, or straight out of the stop bit for back-to-back frames
  assign pop     = tx_en & ~empty & (state == IDLE | (state == STOP & bit_end));
  assign flush   = wr & RegSelect == 3'd4 & DataIn[1];
  // a pop in the same cycle frees a slot, so a write to a full FIFO still lands
  assign push    = wr & RegSelect == 3'd0 & (~full | pop);
  assign lsr     = {1'b0, empty & state == IDLE, ~full, 3'b000, ovr, empty};
  assign TxBusy  = state != IDLE | ~empty;
  // register readback is purely combinational and only during a read cycle
  always_comb
    DataOut = ~(Port_Enable & WE_L) ? 8'h00 :
              RegSelect == 3'd1 ? div[7:0] :
              RegSelect == 3'd2 ? div[15:8] :
              RegSelect == 3'd3 ? lsr :
              RegSelect == 3'd4 ? {7'd0, tx_en} : 8'h00;
  // one access per bus cycle, re-armed once Port_Enable is seen low
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) armed <= 1'b1;
    else armed <= ~Port_Enable | (armed & ~access);
  // control registers, overrun flag and FIFO bookkeeping
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      tx_en  <= 1'b0;
      ovr    <= 1'b0;
      div    <= RESET_DIVISOR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr & RegSelect == 3'd1) div[7:0] <= DataIn;
      if (wr & RegSelect == 3'd2) div[15:8] <= DataIn;
      if (wr & RegSelect == 3'd4) tx_en <= DataIn[0];
      if (wr & RegSelect == 3'd0 & full & ~pop) ovr <= 1'b1;
      else if (rd & RegSelect == 3'd3) ovr <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= flush ? wr_ptr : rd_ptr + AW'(pop);
      count  <= flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // FIFO storage needs no reset; occupancy is tracked by count
  always_ff @(posedge Clock)
    if (push) mem[wr_ptr] <= DataIn;
  // 8N1 shifter: each bit lasts one period, timer reloaded at every bit boundary
  always_ff @(posedge Clock or negedge Reset_L)
    if (!Reset_L) begin
      state   <= IDLE;
      TxD     <= 1'b1;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      state <= START;
      TxD   <= 1'b0;
      shreg <= mem[rd_ptr];
      cnt   <= period;
    end else if (state != IDLE) begin
      cnt <= bit_end ? period : cnt - 16'd1;
      if (bit_end && state == START) begin
        state   <= DATA;
        TxD     <= shreg[0];
        shreg   <= shreg >> 1;
        bit_idx <= 3'd0;
      end else if (bit_end && state == DATA && bit_idx == 3'd7) begin
        state <= STOP;
        TxD   <= 1'b1;
      end else if (bit_end && state == DATA) begin
        TxD     <= shreg[0];
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end else if (bit_end) begin
        state <= IDLE;
        TxD   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_serial_tx_port.sv
// tb_serial_tx_port: randomized and directed checks of serial_tx_port against a queue-based model
module tb_serial_tx_port;
  localparam int DEPTH = 4;
  logic       Clock = 1'b0, Reset_L = 1'b0, Port_Enable = 1'b0, WE_L = 1'b1;
  logic [2:0] RegSelect = '0;
  logic [7:0] DataIn = '0;
  logic [7:0] DataOut;
  logic       TxD, TxBusy;
  int n_chk = 0, n_pass = 0;
  byte unsigned mq[$];
  byte unsigned wq[$];
  bit m_ovr = 1'b0;

  serial_tx_port #(.FIFO_DEPTH(DEPTH), .RESET_DIVISOR(16'h0001)) dut (
    .Clock(Clock), .Reset_L(Reset_L), .Port_Enable(Port_Enable), .RegSelect(RegSelect),
    .WE_L(WE_L), .DataIn(DataIn), .DataOut(DataOut), .TxD(TxD), .TxBusy(TxBusy));

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [7:0] d);
    @(negedge Clock);
    Port_Enable = 1'b1; WE_L = 1'b0; RegSelect = sel; DataIn = d;
    @(negedge Clock);
    Port_Enable = 1'b0; WE_L = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] sel, output logic [7:0] d);
    @(negedge Clock);
    Port_Enable = 1'b1; WE_L = 1'b1; RegSelect = sel;
    #1 d = DataOut;
    @(negedge Clock);
    Port_Enable = 1'b0;
  endtask

  function automatic logic [7:0] lsr_exp();
    return {1'b0, mq.size() == 0, mq.size() < DEPTH, 3'b000, m_ovr, mq.size() == 0};
  endfunction

  // receive one frame sampled on falling edges; bits[0] is the start bit, bits[9] the stop bit
  task automatic rx_frame(input int p, input int max_wait, output logic [9:0] bits,
                          output bit ok, output int waited);
    logic v;
    ok = 1'b1; waited = 0; bits = '0; v = 1'b0;
    do begin @(negedge Clock); waited++; end while (TxD !== 1'b0 && waited < max_wait);
    if (TxD !== 1'b0) begin ok = 1'b0; return; end
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < p; j++) begin
        if (b != 0 || j != 0) @(negedge Clock);
        if (j == 0) v = TxD;
        else if (TxD !== v) ok = 1'b0;
      end
      bits[b] = v;
    end
  endtask

  // queue wq while disabled, check LSR against the model, then enable and check every frame
  task automatic batch(input int p);
    logic [7:0] r;
    logic [9:0] bits;
    bit ok;
    int w;
    byte unsigned e;
    bus_write(3'd4, 8'h00);
    foreach (wq[i]) begin
      bus_write(3'd0, wq[i]);
      if (mq.size() < DEPTH) mq.push_back(wq[i]);
      else m_ovr = 1'b1;
    end
    bus_read(3'd3, r); chk("lsr_after_fill", r, lsr_exp());
    m_ovr = 1'b0;
    bus_read(3'd3, r); chk("lsr_reread", r, lsr_exp());
    bus_write(3'd4, 8'h01);
    for (int k = 0; mq.size() > 0; k++) begin
      e = mq.pop_front();
      rx_frame(p, 12, bits, ok, w);
      chk("frame_bits", bits, {1'b1, e, 1'b0});
      chk("bit_timing", ok, 1);
      if (k > 0) chk("no_gap", w, 1);
    end
    @(negedge Clock);
    chk("busy_after", TxBusy, 0);
    bus_write(3'd4, 8'h00);
    bus_read(3'd3, r); chk("lsr_idle", r, 8'h61);
  endtask

  initial begin : main
    logic [7:0] r;
    logic [9:0] bits;
    bit ok;
    int w, zeros, dll, p;
    repeat (3) @(negedge Clock);
    Reset_L = 1'b1;
    bus_read(3'd3, r); chk("rst_lsr", r, 8'h61);
    chk("rst_txd", TxD, 1);
    chk("rst_busy", TxBusy, 0);
    bus_read(3'd1, r); chk("rst_dll", r, 8'h01);
    bus_read(3'd2, r); chk("rst_dlm", r, 8'h00);
    bus_read(3'd4, r); chk("rst_ctrl", r, 8'h00);
    bus_read(3'd0, r); chk("thr_read", r, 8'h00);
    bus_read(3'd6, r); chk("rsvd_read", r, 8'h00);
    chk("idle_dataout", DataOut, 8'h00);

    bus_write(3'd1, 8'h04); bus_write(3'd2, 8'h00); bus_write(3'd4, 8'h01);
    bus_write(3'd0, 8'hA5);
    rx_frame(4, 12, bits, ok, w);
    chk("a5_bits", bits, 10'b1_1010_0101_0);
    chk("a5_timing", ok, 1);
    @(negedge Clock);
    chk("a5_busy_fall", TxBusy, 0);

    bus_write(3'd1, 8'h02);
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    batch(2);

    bus_write(3'd4, 8'h00);
    @(negedge Clock);
    Port_Enable = 1'b1; WE_L = 1'b0; RegSelect = 3'd0; DataIn = 8'h77;
    repeat (6) @(negedge Clock);
    Port_Enable = 1'b0; WE_L = 1'b1;
    bus_read(3'd3, r); chk("hold_one_entry", r, 8'h20);
    repeat (3) bus_write(3'd0, 8'h11);
    bus_read(3'd3, r); chk("hold_full_no_ovr", r, 8'h00);
    bus_write(3'd4, 8'h02);
    bus_read(3'd3, r); chk("flush_lsr", r, 8'h61);
    bus_read(3'd4, r); chk("flush_reads0", r, 8'h00);

    bus_write(3'd4, 8'h00);
    foreach (wq[i]) wq[i] = 8'h00;
    bus_write(3'd0, 8'h81); bus_write(3'd0, 8'h42); bus_write(3'd0, 8'h99);
    bus_write(3'd4, 8'h01);
    fork
      rx_frame(2, 12, bits, ok, w);
      begin repeat (6) @(negedge Clock); bus_write(3'd4, 8'h00); end
    join
    chk("dis_frame_bits", bits, {1'b1, 8'h81, 1'b0});
    chk("dis_timing", ok, 1);
    zeros = 0;
    for (int i = 0; i < 30; i++) begin @(negedge Clock); if (TxD !== 1'b1) zeros++; end
    chk("dis_stays_idle", zeros, 0);
    bus_read(3'd3, r); chk("dis_lsr", r, 8'h20);
    chk("dis_lsr0", r[0], 0);
    chk("dis_busy", TxBusy, 1);
    bus_write(3'd4, 8'h02);
    bus_read(3'd3, r); chk("dis_flush", r, 8'h61);

    bus_write(3'd1, 8'h04);
    bus_write(3'd0, 8'h30); bus_write(3'd0, 8'h55);
    bus_write(3'd4, 8'h01);
    w = 0;
    do begin @(negedge Clock); w++; end while (TxD !== 1'b0 && w < 12);
    chk("rst_frame_started", TxD, 0);
    repeat (17) @(negedge Clock);
    chk("rst_at_bit3", TxD, 0);
    #2 Reset_L = 1'b0;
    #1 chk("rst_async_txd", TxD, 1);
    chk("rst_async_busy", TxBusy, 0);
    @(negedge Clock);
    Reset_L = 1'b1;
    bus_read(3'd3, r); chk("rst2_lsr", r, 8'h61);
    bus_read(3'd1, r); chk("rst2_dll", r, 8'h01);
    bus_read(3'd4, r); chk("rst2_ctrl", r, 8'h00);
    zeros = 0;
    for (int i = 0; i < 20; i++) begin @(negedge Clock); if (TxD !== 1'b1) zeros++; end
    chk("rst2_txd_idle", zeros, 0);

    for (int t = 0; t < 6; t++) begin
      dll = $urandom_range(0, 5);
      p = dll == 0 ? 1 : dll;
      bus_write(3'd1, 8'(dll)); bus_write(3'd2, 8'h00);
      bus_read(3'd1, r); chk("rnd_dll", r, 8'(dll));
      wq.delete();
      repeat ($urandom_range(1, 6)) wq.push_back(8'($urandom));
      batch(p);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_tx_port.md
SERIAL_TX_PORT -- requirements
Module: serial_tx_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4; transmit FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter RESET_DIVISOR, default 16'h0001; baud divisor value loaded at reset.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Port_Enable  input  1  chip enable from the IO address decoder, active high.
REQ-006 SHALL have port RegSelect  input  3  register offset, driven from Address[3:1].
REQ-007 SHALL have port WE_L  input  1  0 = write cycle, 1 = read cycle.
REQ-008 SHALL have port DataIn  input  8  write data from D15-D8.
REQ-009 SHALL have port DataOut  output  8  read data to D15-D8.
REQ-010 SHALL have port TxD  output  1  serial line, idle high.
REQ-011 SHALL have port TxBusy  output  1  high while a frame is shifting or the FIFO is non-empty.

Function
REQ-012 SHALL accept one access per bus cycle: the access fires on the first rising Clock edge on which Port_Enable=1; no further access fires until Port_Enable has been sampled 0.
REQ-013 SHALL decode registers by RegSelect: 0 THR (write-only), 1 DLL, 2 DLM (divisor low and high bytes, read/write), 3 LSR (read-only), 4 CTRL (read/write), 5-7 reserved.
REQ-014 SHALL, on a THR write, push DataIn into the FIFO when it is not full; when it is full, drop the byte and set LSR[1] (overrun).
REQ-015 SHALL drive LSR as: [0] FIFO empty, [1] overrun, [5] FIFO not full, [6] FIFO empty and shifter idle; all other bits 0.
REQ-016 SHALL clear LSR[1] on the access edge of an LSR read; the read itself SHALL return the value before clearing.
REQ-017 SHALL drive CTRL as: [0] TX enable; [1] flush (write-1 self-clearing, reads 0); other bits read 0.
REQ-018 SHALL, on a flush, empty the FIFO in the same cycle without aborting a frame already in progress.
REQ-019 SHALL drive DataOut combinationally from RegSelect while Port_Enable=1 and WE_L=1; THR and reserved offsets return 8'h00, and DataOut SHALL be 8'h00 otherwise.
REQ-020 SHALL ignore writes to reserved offsets and to LSR.
REQ-021 SHALL time the bit period as max(divisor,1) Clock cycles, using a 16-bit down-counter reloaded at every bit boundary.
REQ-022 SHALL implement FSM IDLE->START->DATA->STOP->IDLE: start bit 0, 8 data bits LSB first, one stop bit 1 (8N1), each bit held exactly one bit period.
REQ-023 SHALL leave IDLE only when CTRL[0]=1 and the FIFO is non-empty, popping the head entry in that cycle; TxD SHALL fall on the following edge.
REQ-024 SHALL, from STOP with CTRL[0]=1 and the FIFO non-empty, go directly to START, giving back-to-back frames with no idle gap.
REQ-025 SHALL, when CTRL[0] is cleared mid-frame, complete the current frame and then stay in IDLE.
REQ-026 SHALL, on a divisor write mid-frame, apply the new value from the next bit boundary.
REQ-027 SHALL, on a THR write and a pop in the same cycle while the FIFO is full, accept the push (no overrun); the FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, while Reset_L=0, hold: TxD=1, TxBusy=0, FSM=IDLE, FIFO empty, LSR[1]=0, CTRL=8'h00, divisor=RESET_DIVISOR, access-armed state re-armed.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame with TxD=1 immediately and discard FIFO contents.

Verification
REQ-030 Reset then read LSR -> DataOut=8'h61; TxD=1.
REQ-031 DLL=8'h04, DLM=8'h00, CTRL=8'h01, THR=8'hA5 -> TxD shows 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; 40 clocks total; TxBusy falls afterwards.
REQ-032 CTRL=0, five THR writes 8'h01..8'h05 -> LSR=8'h02 (full, overrun); a second LSR read returns 8'h00 with bit1 clear; CTRL=1 sends 01,02,03,04 back-to-back with no idle gap.
REQ-033 Port_Enable held high for 6 cycles during one THR write -> exactly one FIFO entry added.
REQ-034 Reset_L pulsed low at data bit 3 -> TxD=1 asynchronously, LSR=8'h61 after release, divisor=8'h01 (readback of DLL).
REQ-035 CTRL cleared during bit 2 with 2 bytes queued -> current frame completes; TxD stays 1; LSR[0]=0.
